can_bus_fabric: RTL
===================

// Module: can_bus_fabric
// PURPOSE
//  Parametrised wired-AND CAN bus for NODES custom_can_node instances; replaces
//  point-to-point cross-wiring in benches and FPGA loopback builds. Resolves
//  lo/hi lanes, adds programmable propagation delay and fault injection, and
//  monitors the resolved bus: SOF count, dominant-run error, run-length done.
//  Synthesisable; sits between node tx outputs and node rx inputs.
// PARAMETERS
//  NODES      2    number of attached nodes (>=1)
//  DELAY      1    bus propagation delay in CLK cycles (0 = combinational path)
//  BIT_TICKS  4    CLK cycles per CAN bit (>=2); monitor sample rate
//  RUN_LEN    120  CLK cycles after reset release until done asserts
// PORTS
//  CLK          in   1      clock, all logic on rising edge
//  RST          in   1      synchronous reset, active-high
//  tx_lo        in   NODES  per-node lo-lane drive, 0 = dominant
//  tx_hi        in   NODES  per-node hi-lane drive, 0 = dominant
//  fault_mode   in   2      0 none, 1 stuck dominant, 2 stuck recessive, 3 bit flip
//  fault_arm    in   1      1-cycle pulse; starts flip window (mode 3 only)
//  rx_lo        out  1      resolved lo lane, fanned out to every node
//  rx_hi        out  1      resolved hi lane, fanned out to every node
//  sof_count    out  16     SOFs detected on rx_lo, saturates at 16'hFFFF
//  dom_run_err  out  1      sticky: >=6 consecutive dominant samples on rx_lo
//  done         out  1      sticky: RUN_LEN cycles elapsed since reset release
// BEHAVIOUR
//  Reset: delay stages and rx_lo/rx_hi = 1 (recessive); sof_count=0;
//   dom_run_err=0; done=0; tick, run, cycle counters=0; flip window cleared.
//   RST mid-operation (incl. during flip) takes effect on that edge.
//  Resolve: bus_x = &tx_x per lane. Fault stage (both lanes identically):
//   mode1 -> 0; mode2 -> 1; mode3 -> ~bus_x while flip window active, else bus_x;
//   mode0 -> bus_x. fault_mode changes take effect the same cycle at stage input.
//  Flip window: fault_arm=1 in mode 3 with window idle -> window active for the
//   next BIT_TICKS cycles exactly; fault_arm during active window ignored;
//   fault_arm in modes 0-2 ignored.
//  Delay: DELAY-stage shift register of recessive-reset flops; rx = stage
//   input delayed DELAY cycles. DELAY=0: rx combinational from fault stage.
//  Bit timer: tick free-runs 0..BIT_TICKS-1, wraps to 0. Sample rx_lo when
//   tick == BIT_TICKS/2 (integer division).
//  Monitor on each sample:
//   recessive -> rec_run++ (saturate at 11); dom_run=0.
//   dominant  -> if rec_run==11, sof_count++ (saturating); rec_run=0;
//                dom_run++ (saturate at 6); dom_run reaching 6 sets dom_run_err.
//   rec_run starts at 0 after reset: first SOF needs 11 recessive samples.
//   dom_run_err and sof_count cleared only by RST.
//  done: cycle counter increments each non-reset cycle; done=1 on the edge
//   where the count reaches RUN_LEN; counter then holds; done stays 1.
//  Widths: counters sized $clog2(param+1); no wrap except tick.
// TESTING
//  T1 NODES=2,DELAY=1: tx_lo=2'b10 -> rx_lo=0 one cycle later; 2'b11 -> rx_lo=1.
//  T2 mode1, tx all 1 -> rx_lo=rx_hi=0 after DELAY; mode2, tx all 0 -> both 1.
//  T3 mode3, tx all 1, pulse fault_arm -> rx_lo=0 for exactly BIT_TICKS=4
//     cycles after DELAY, then 1; second arm inside window has no effect.
//  T4 BIT_TICKS=4: 11 recessive bits then 1 dominant bit -> sof_count=1;
//     extend to 6 dominant bits -> dom_run_err=1 at 6th sample, stays 1.
//  T5 RST asserted mid flip window and after sof_count=1 -> next cycle
//     rx=1, sof_count=0, dom_run_err=0, done=0, no residual flip.
//  T6 RUN_LEN=120 -> done=0 at edge 119, done=1 at edge 120 after RST low; held.

Source files
------------

// File: rtl/can_bus_fabric.sv
// Wired-AND CAN bus model: lane resolve, fault injection, delay line, monitor.
// Ports: CLK/RST, tx_lo/tx_hi in, fault_mode/fault_arm in, rx_lo/rx_hi,
// sof_count, dom_run_err, done out.
module can_bus_fabric #(
  parameter int NODES     = 2,
  parameter int DELAY     = 1,
  parameter int BIT_TICKS = 4,
  parameter int RUN_LEN   = 120
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NODES-1:0] tx_lo,
  input  logic [NODES-1:0] tx_hi,
  input  logic [1:0]       fault_mode,
  input  logic             fault_arm,
  output logic             rx_lo,
  output logic             rx_hi,
  output logic [15:0]      sof_count,
  output logic             dom_run_err,
  output logic             done
);

  localparam int TW = $clog2(BIT_TICKS + 1);
  localparam int CW = $clog2(RUN_LEN + 1);
  localparam logic [TW-1:0] TLAST = TW'(BIT_TICKS - 1);
  localparam logic [TW-1:0] TSAMP = TW'(BIT_TICKS / 2);
  localparam logic [TW-1:0] WLEN  = TW'(BIT_TICKS);
  localparam logic [CW-1:0] CLAST = CW'(RUN_LEN);

  logic          bus_lo, bus_hi;
  logic          f_lo, f_hi;
  logic          win_act;
  logic [TW-1:0] win_q, win_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    rec_q, rec_d;
  logic [2:0]    dom_q, dom_d;
  logic [15:0]   sof_q, sof_d;
  logic          err_q, err_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          done_q, done_d;

  assign bus_lo  = &tx_lo;
  assign bus_hi  = &tx_hi;
  assign win_act = (win_q != '0);

  always_comb begin
    f_lo = bus_lo;
    f_hi = bus_hi;
    unique case (fault_mode)
      2'd1: begin f_lo = 1'b0; f_hi = 1'b0; end
      2'd2: begin f_lo = 1'b1; f_hi = 1'b1; end
      2'd3: begin f_lo = bus_lo ^ win_act; f_hi = bus_hi ^ win_act; end
      default: ;
    endcase
  end

  // Arm is only honoured while idle, so a running window is never extended.
  always_comb begin
    win_d = '0;
    if (win_act)
      win_d = win_q - TW'(1);
    else if (fault_arm && fault_mode == 2'd3)
      win_d = WLEN;
  end

  generate
    if (DELAY == 0) begin : g_nodly
      assign rx_lo = f_lo;
      assign rx_hi = f_hi;
    end else begin : g_dly
      logic [DELAY-1:0] lo_q, hi_q;
      always_ff @(posedge CLK) begin
        if (RST) begin
          lo_q <= '1;
          hi_q <= '1;
        end else begin
          lo_q[0] <= f_lo;
          hi_q[0] <= f_hi;
          for (int i = 1; i < DELAY; i++) begin
            lo_q[i] <= lo_q[i-1];
            hi_q[i] <= hi_q[i-1];
          end
        end
      end
      assign rx_lo = lo_q[DELAY-1];
      assign rx_hi = hi_q[DELAY-1];
    end
  endgenerate

  always_comb begin
    tick_d = (tick_q == TLAST) ? '0 : tick_q + TW'(1);
    rec_d  = rec_q;
    dom_d  = dom_q;
    sof_d  = sof_q;
    err_d  = err_q;
    if (tick_q == TSAMP) begin
      if (rx_lo) begin
        rec_d = (rec_q == 4'd11) ? 4'd11 : rec_q + 4'd1;
        dom_d = '0;
      end else begin
        // A dominant sample after 11 recessive ones is a start of frame.
        if (rec_q == 4'd11 && sof_q != 16'hFFFF)
          sof_d = sof_q + 16'd1;
        rec_d = '0;
        dom_d = (dom_q == 3'd6) ? 3'd6 : dom_q + 3'd1;
        if (dom_d == 3'd6)
          err_d = 1'b1;
      end
    end
  end

  always_comb begin
    cyc_d  = (cyc_q == CLAST) ? cyc_q : cyc_q + CW'(1);
    done_d = done_q | (cyc_d == CLAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q  <= '0;
      tick_q <= '0;
      rec_q  <= '0;
      dom_q  <= '0;
      sof_q  <= '0;
      err_q  <= 1'b0;
      cyc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      tick_q <= tick_d;
      rec_q  <= rec_d;
      dom_q  <= dom_d;
      sof_q  <= sof_d;
      err_q  <= err_d;
      cyc_q  <= cyc_d;
      done_q <= done_d;
    end
  end

  assign sof_count   = sof_q;
  assign dom_run_err = err_q;
  assign done        = done_q;

endmodule
